sram_mem_controller: RTL and testbench
======================================

SRAM_MEM_CONTROLLER -- requirements
Module: sram_mem_controller

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 5, meaning the number of clock cycles per 16-bit SRAM half-access (legal 2..15).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'd1024, meaning the byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 MEM_R_EN  input  1  load request from MEM stage (control-unit MEM_R_EN).
REQ-006 MEM_W_EN  input  1  store request from MEM stage (control-unit MEM_W_EN).
REQ-007 address  input  32  byte address of the access (ALU result).
REQ-008 ST_val  input  32  store data.
REQ-009 ready  output  1  high when no access is pending or the current access completes; low freezes the pipeline.
REQ-010 MEM_result  output  32  load data.
REQ-011 SRAM_ADDR  output  18  SRAM half-word address.
REQ-012 SRAM_DQ_I  input  16  SRAM read data.
REQ-013 SRAM_DQ_O  output  16  SRAM write data.
REQ-014 SRAM_DQ_OE  output  1  high drives SRAM_DQ_O onto the bus.
REQ-015 SRAM_WE_N  output  1  SRAM write strobe, active-low.
REQ-016 SRAM_OE_N  output  1  SRAM output enable, active-low.

Function
REQ-017 The FSM SHALL have states IDLE, LOW, HIGH and DONE.
REQ-018 IDLE with MEM_R_EN or MEM_W_EN high SHALL latch address, ST_val and the op type, then go to LOW; otherwise IDLE SHALL hold.
REQ-019 When MEM_R_EN and MEM_W_EN are both high, the access SHALL be a read and the write SHALL be ignored.
REQ-020 Word index SHALL be (address - BASE_ADDR) >> 2, truncated to 17 bits, and address[1:0] SHALL be ignored.
REQ-021 SRAM_ADDR SHALL be {index, 1'b0} in LOW, {index, 1'b1} in HIGH, and held at the last value otherwise.
REQ-022 A 4-bit counter SHALL run 0..WAIT_CYCLES-1 in LOW and in HIGH; on the terminal count LOW SHALL go to HIGH and HIGH SHALL go to DONE, and the counter SHALL clear.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE, and a new request SHALL NOT be accepted in DONE.
REQ-024 ready SHALL equal NOT(MEM_R_EN OR MEM_W_EN) in IDLE, 0 in LOW and HIGH, and 1 in DONE, combinationally from state and inputs.
REQ-025 Latency SHALL be: request in cycle 0 (IDLE), ready=1 in cycle 2*WAIT_CYCLES+1 (cycle 11 with default).
REQ-026 Write, LOW/HIGH: SRAM_DQ_OE=1; SRAM_DQ_O = latched ST_val[15:0] in LOW, ST_val[31:16] in HIGH; SRAM_WE_N=0 for counter < WAIT_CYCLES-1, and 1 on the terminal cycle (data hold).
REQ-027 Read, LOW/HIGH: SRAM_OE_N=0, SRAM_DQ_OE=0, SRAM_WE_N=1; SRAM_DQ_I SHALL be captured on the terminal cycle into MEM_result[15:0] in LOW and into MEM_result[31:16] in HIGH.
REQ-028 In IDLE and DONE: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_OE=0.
REQ-029 MEM_result SHALL hold its value until the next read's capture, and writes SHALL NOT modify it.
REQ-030 Deassertion of MEM_R_EN or MEM_W_EN during LOW or HIGH SHALL NOT abort the access; it SHALL complete using the latched values.

Reset
REQ-031 On rst_n low, regardless of clk or state: state=IDLE, counter=0, MEM_result=0, SRAM_ADDR=0, SRAM_DQ_O=0, SRAM_DQ_OE=0, SRAM_WE_N=1, SRAM_OE_N=1.
REQ-032 Reset asserted mid-access SHALL abandon the access with no further SRAM strobes; after release, ready SHALL reflect the request inputs per IDLE.

Verification
REQ-033 The bench SHALL cover a read: SRAM model holds 0x1234 at half-address 2 and 0xABCD at 3; MEM_R_EN=1, address=1028 -> ready=0 for cycles 0..10, ready=1 at cycle 11, MEM_result=0xABCD1234.
REQ-034 The bench SHALL cover a write: MEM_W_EN=1, address=1032, ST_val=0xDEADBEEF -> SRAM half 4=0xBEEF, half 5=0xDEAD; SRAM_WE_N low 4 cycles per half; ready=1 at cycle 11; MEM_result unchanged.
REQ-035 The bench SHALL cover no request: MEM_R_EN=MEM_W_EN=0 for 20 cycles -> ready=1 throughout, SRAM_WE_N=SRAM_OE_N=1, state IDLE.
REQ-036 The bench SHALL cover simultaneous requests: MEM_R_EN=MEM_W_EN=1, address=1028 -> read performed, SRAM_WE_N stays 1, MEM_result=0xABCD1234.
REQ-037 The bench SHALL cover reset mid-write: rst_n low at cycle 7 of a write -> SRAM_WE_N=1 and SRAM_DQ_OE=0 immediately, half 5 unmodified, and ready=0 with state LOW the cycle after release if MEM_W_EN is still high at that edge.
REQ-038 The bench SHALL cover back-to-back accesses: write 0x00000005 to 1024, then read 1024 with the request held through DONE -> second access starts the cycle after DONE, ready=1 at cycle 23, MEM_result=0x00000005.

Source files
------------

// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   Bridges a 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM.
//   Each access is split into two half-word phases (LOW then HIGH), each
//   lasting WAIT_CYCLES clocks. The pipeline is frozen through ready while
//   an access is in flight.
//
//   Handshake: a request (MEM_R_EN or MEM_W_EN) is taken only in IDLE. While
//   it is in flight ready is low. ready returns high for exactly one cycle
//   (DONE), in which the access is complete and MEM_result holds load data.
//   Dropping a request mid-access does not abort it; a request present in
//   DONE is ignored and is taken in the following IDLE cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   MEM_R_EN, MEM_W_EN  load / store request (read wins when both are high)
//   address, ST_val     byte address and store data
//   ready               pipeline may advance
//   MEM_result          load data, held until the next load capture
//   SRAM_ADDR           half-word address to the SRAM
//   SRAM_DQ_I/O/OE      SRAM data in, data out, output-drive enable
//   SRAM_WE_N/OE_N      SRAM write strobe and output enable (active-low)
//   fsm_state           debug view of the FSM: 0 IDLE, 1 LOW, 2 HIGH, 3 DONE
module sram_mem_controller #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] ST_val,
  output logic        ready,
  output logic [31:0] MEM_result,
  output logic [17:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_I,
  output logic [15:0] SRAM_DQ_O,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        is_read_q;
  logic [31:0] st_q;
  logic [16:0] index_q;
  logic [17:0] addr_q;
  logic        req;
  logic        terminal;
  logic [16:0] index_next;

  assign req        = MEM_R_EN | MEM_W_EN;
  assign terminal   = (cnt == 4'(WAIT_CYCLES - 1));
  // Word index; the low two byte-address bits drop out with the shift.
  assign index_next = 17'((address - BASE_ADDR) >> 2);
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      is_read_q  <= 1'b0;
      st_q       <= 32'd0;
      index_q    <= 17'd0;
      addr_q     <= 18'd0;
      MEM_result <= 32'd0;
    end else begin
      state  <= next_state;
      // Remembers the last driven address so it holds outside LOW/HIGH.
      addr_q <= SRAM_ADDR;
      if (state == IDLE && req) begin
        is_read_q <= MEM_R_EN;
        st_q      <= ST_val;
        index_q   <= index_next;
      end
      if (state == LOW || state == HIGH) begin
        cnt <= terminal ? 4'd0 : cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
      // Read data is sampled at the end of the final wait cycle of a half.
      if (is_read_q && terminal) begin
        if (state == LOW)  MEM_result[15:0]  <= SRAM_DQ_I;
        if (state == HIGH) MEM_result[31:16] <= SRAM_DQ_I;
      end
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    SRAM_ADDR  = addr_q;
    SRAM_DQ_O  = 16'd0;
    SRAM_DQ_OE = 1'b0;
    SRAM_WE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) next_state = LOW;
      end
      LOW: begin
        SRAM_ADDR = {index_q, 1'b0};
        if (is_read_q) begin
          SRAM_OE_N = 1'b0;
        end else begin
          SRAM_DQ_OE = 1'b1;
          SRAM_DQ_O  = st_q[15:0];
          // Strobe released on the last cycle so data is held past WE rise.
          SRAM_WE_N  = terminal;
        end
        if (terminal) next_state = HIGH;
      end
      HIGH: begin
        SRAM_ADDR = {index_q, 1'b1};
        if (is_read_q) begin
          SRAM_OE_N = 1'b0;
        end else begin
          SRAM_DQ_OE = 1'b1;
          SRAM_DQ_O  = st_q[31:16];
          SRAM_WE_N  = terminal;
        end
        if (terminal) next_state = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
module tb_sram_mem_controller;

  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          LAT  = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] ST_val = 32'd0;
  logic        ready;
  logic [31:0] MEM_result;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_I;
  logic [15:0] SRAM_DQ_O;
  logic        SRAM_DQ_OE;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  sram_mem_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .ST_val(ST_val), .ready(ready), .MEM_result(MEM_result),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_I(SRAM_DQ_I), .SRAM_DQ_O(SRAM_DQ_O),
    .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  // Asynchronous SRAM: data drives out while OE_N is low; a write commits
  // on the rising edge of WE_N with the address/data seen while it was low.
  logic [15:0] sram_mem [0:1023];
  logic        we_prev_low = 1'b0;
  logic [9:0]  wa;
  logic [15:0] wd;

  assign SRAM_DQ_I = (!SRAM_OE_N) ? sram_mem[SRAM_ADDR[9:0]] : 16'h0000;

  always @(negedge clk) begin
    if (rst_n && we_prev_low && SRAM_WE_N) sram_mem[wa] <= wd;
    if (!SRAM_WE_N) begin
      wa <= SRAM_ADDR[9:0];
      wd <= SRAM_DQ_O;
    end
    we_prev_low <= !SRAM_WE_N;
  end

  // ---------------- reference model ----------------
  // Word-level memory image and the last loaded value.
  logic [31:0] ref_word [int];
  logic [31:0] ref_result;

  function automatic logic [31:0] ref_get(input int k);
    return ref_word.exists(k) ? ref_word[k] : 32'd0;
  endfunction

  task automatic ref_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] st);
    int k;
    k = int'((addr - BASE) >> 2);
    if (rd) ref_result = ref_get(k);
    else if (wr) ref_word[k] = st;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one access starting at the next IDLE cycle and follows it until
  // ready. Returns cycle of ready (-1 on timeout) and strobe-low counts.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] st, input logic drop,
                           output int lat, output int we_low, output int oe_low);
    @(posedge clk); #1;
    MEM_R_EN = rd; MEM_W_EN = wr; address = addr; ST_val = st;
    lat = -1; we_low = 0; oe_low = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!SRAM_WE_N) we_low++;
      if (!SRAM_OE_N) oe_low++;
      if (c == 0) chk("ready_low_at_request", {31'd0, ready}, 32'd0);
      if (c > 0 && ready) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
      if (drop) begin
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        address = $urandom; ST_val = $urandom;
      end
    end
    @(posedge clk); #1;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] exp_result;
    int          exp_we_low;
    int          exp_oe_low;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat, we_low, oe_low, k;
    logic rd, wr, drop;
    logic [31:0] addr, st;

    for (int i = 0; i < 1024; i++) sram_mem[i] = 16'h0000;
    sram_mem[2] = 16'h1234;
    sram_mem[3] = 16'hABCD;
    ref_word[1] = 32'hABCD1234;
    ref_result  = 32'd0;

    // reset state
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_result", MEM_result, 32'd0);
    chk("rst_sram_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("rst_dq_o", {16'd0, SRAM_DQ_O}, 32'd0);
    chk("rst_strobes", {29'd0, SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N}, 32'b011);
    chk("rst_state", {30'd0, fsm_state}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // no request for 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_ready_we_oe_state", {27'd0, ready, SRAM_WE_N, SRAM_OE_N, fsm_state},
          {27'd0, 1'b1, 1'b1, 1'b1, 2'd0});
    end

    // directed table
    vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'd0,          32'hABCD1234, 0,           2 * W};
    vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF,   32'hABCD1234, 2 * (W - 1), 0};
    vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'h55555555,   32'hABCD1234, 0,           2 * W};
    vecs[3] = '{1'b1, 1'b0, 32'd1035, 32'd0,          32'hDEADBEEF, 0,           2 * W};
    vecs[4] = '{1'b0, 1'b1, 32'd1040, 32'h0BADF00D,   32'hDEADBEEF, 2 * (W - 1), 0};
    for (int i = 0; i < 5; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].st, 1'b0, lat, we_low, oe_low);
      ref_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].st);
      chk("tbl_latency", lat, LAT);
      chk("tbl_result", MEM_result, vecs[i].exp_result);
      chk("tbl_we_low_cycles", we_low, vecs[i].exp_we_low);
      chk("tbl_oe_low_cycles", oe_low, vecs[i].exp_oe_low);
      if (i == 1) begin
        chk("wr_half4", {16'd0, sram_mem[4]}, 32'h0000BEEF);
        chk("wr_half5", {16'd0, sram_mem[5]}, 32'h0000DEAD);
      end
    end

    // back-to-back: write 5 to 1024, read 1024 held through DONE
    @(posedge clk); #1;
    MEM_W_EN = 1'b1; address = 32'd1024; ST_val = 32'd5;
    for (int c = 0; c <= 23; c++) begin
      if (c == 11) begin
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
      end
      @(negedge clk);
      chk("b2b_ready", {31'd0, ready}, {31'd0, (c == 11 || c == 23)});
      if (c == 12) chk("b2b_state_idle", {30'd0, fsm_state}, 32'd0);
      if (c == 13) chk("b2b_state_low", {30'd0, fsm_state}, 32'd1);
      @(posedge clk); #1;
    end
    MEM_R_EN = 1'b0;
    ref_access(1'b0, 1'b1, 32'd1024, 32'd5);
    ref_access(1'b1, 1'b0, 32'd1024, 32'd0);
    chk("b2b_result", MEM_result, 32'd5);
    chk("b2b_model_result", MEM_result, ref_result);

    // reset in cycle 7 of a write to 1032
    @(posedge clk); #1;
    MEM_W_EN = 1'b1; address = 32'd1032; ST_val = 32'h11112222;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {30'd0, SRAM_WE_N, SRAM_DQ_OE}, 32'b10);
    chk("midrst_state", {30'd0, fsm_state}, 32'd0);
    @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready_after", {31'd0, ready}, 32'd0);
    chk("midrst_state_low", {30'd0, fsm_state}, 32'd1);
    chk("midrst_half5_kept", {16'd0, sram_mem[5]}, 32'h0000DEAD);
    chk("midrst_half4_done", {16'd0, sram_mem[4]}, 32'h00002222);
    chk("midrst_result_cleared", MEM_result, 32'd0);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        break;
      end
    end
    chk("midrst_restart_done", (lat >= 0) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
    MEM_W_EN = 1'b0;
    ref_word[2] = 32'h11112222;
    ref_result  = 32'd0;

    // randomized accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      rd   = 1'($urandom_range(0, 1));
      wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      k    = $urandom_range(0, 255);
      addr = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
      st   = $urandom;
      drop = 1'($urandom_range(0, 1));
      do_access(rd, wr, addr, st, drop, lat, we_low, oe_low);
      ref_access(rd, wr, addr, st);
      chk("rnd_latency", lat, LAT);
      chk("rnd_result", MEM_result, ref_result);
      chk("rnd_we_low_cycles", we_low, rd ? 0 : 2 * (W - 1));
      chk("rnd_oe_low_cycles", oe_low, rd ? 2 * W : 0);
      chk("rnd_mem_image", {sram_mem[2 * k + 1], sram_mem[2 * k]}, ref_get(k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
